// File: rtl/key_debounce_bank.sv
// Bank of independent key debouncers with press/release pulses and hold detect.
// Ports: CLK, RST_N (async low); in_key raw keys; KEY/PRESS/RELEASE/HOLD per channel; ANY_KEY.
module key_debounce_bank #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DEB_CYCLES    = 5000,
  parameter int unsigned HOLD_CYCLES   = 0,
  parameter int unsigned CNT_W         = 22,
  parameter bit          ACTIVE_LOW_IN = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] in_key,
  output logic [N_CH-1:0] KEY,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] HOLD,
  output logic            ANY_KEY
);

  if (N_CH == 0 || N_CH > 32 || DEB_CYCLES == 0 ||
      64'(DEB_CYCLES) >= (64'd1 << CNT_W) ||
      64'(HOLD_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_param
    $error("key_debounce_bank: parameter out of range");
  end

  // Raw level of a released key; XOR with it maps raw to 1 = pressed.
  localparam logic [N_CH-1:0] IDLE_RAW =
    ACTIVE_LOW_IN ? {N_CH{1'b1}} : {N_CH{1'b0}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  sync2_q;
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  st_q;
  logic [N_CH-1:0]  st_d;
  logic [N_CH-1:0]  press_q;
  logic [N_CH-1:0]  rel_q;
  logic [CNT_W-1:0] dc_q [N_CH];
  logic [CNT_W-1:0] dc_d [N_CH];

  assign s = sync2_q ^ IDLE_RAW;

  // Disagreeing samples count up; the last one flips the state.
  always_comb begin
    st_d = st_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      dc_d[i] = '0;
      if (s[i] != st_q[i]) begin
        if (dc_q[i] == DEB_LAST) begin
          st_d[i] = ~st_q[i];
        end else begin
          dc_d[i] = dc_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      st_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        dc_q[i] <= '0;
      end
    end else begin
      sync1_q <= in_key;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      press_q <= st_d & ~st_q;
      rel_q   <= ~st_d & st_q;
      for (int i = 0; i < int'(N_CH); i++) begin
        dc_q[i] <= dc_d[i];
      end
    end
  end

  if (HOLD_CYCLES > 0) begin : g_hold
    localparam logic [CNT_W-1:0] HMAX = CNT_W'(HOLD_CYCLES);
    logic [CNT_W-1:0] hc_q [N_CH];
    logic [CNT_W-1:0] hc_d [N_CH];

    // Saturating press-duration counter, cleared while released.
    always_comb begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hc_d[i] = '0;
        if (st_q[i]) begin
          if (hc_q[i] == HMAX) begin
            hc_d[i] = hc_q[i];
          end else begin
            hc_d[i] = hc_q[i] + CNT_W'(1);
          end
        end
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < int'(N_CH); i++) begin
          hc_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < int'(N_CH); i++) begin
          hc_q[i] <= hc_d[i];
        end
      end
    end

    always_comb begin
      for (int i = 0; i < int'(N_CH); i++) begin
        HOLD[i] = st_q[i] && (hc_q[i] == HMAX);
      end
    end
  end else begin : g_no_hold
    assign HOLD = '0;
  end

  assign KEY     = st_q;
  assign PRESS   = press_q;
  assign RELEASE = rel_q;
  assign ANY_KEY = |st_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed scoreboard bench for key_debounce_bank.
// Two instances: active-low 4-channel with hold, active-high 1-channel.
module tb_key_debounce_bank;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] in_key = 4'hF;
  logic [3:0] KEY, PRESS, RELEASE, HOLD;
  logic       ANY_KEY;
  logic [0:0] in2 = 1'b0;
  logic [0:0] KEY2, PRESS2, REL2, HOLD2;
  logic       ANY2;

  always #5 CLK = ~CLK;

  key_debounce_bank #(
    .N_CH(4), .DEB_CYCLES(4), .HOLD_CYCLES(10),
    .CNT_W(8), .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .in_key(in_key),
    .KEY(KEY), .PRESS(PRESS), .RELEASE(RELEASE),
    .HOLD(HOLD), .ANY_KEY(ANY_KEY)
  );

  key_debounce_bank #(
    .N_CH(1), .DEB_CYCLES(1), .HOLD_CYCLES(0),
    .CNT_W(4), .ACTIVE_LOW_IN(1'b0)
  ) dut2 (
    .CLK(CLK), .RST_N(RST_N), .in_key(in2),
    .KEY(KEY2), .PRESS(PRESS2), .RELEASE(REL2),
    .HOLD(HOLD2), .ANY_KEY(ANY2)
  );

  typedef struct {
    int          c;
    string       tag;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [21:0] pk(
    logic [3:0] k, logic [3:0] p, logic [3:0] r,
    logic [3:0] h, logic [2:0] d2);
    return {k, p, r, h, |k, d2, 1'b0, d2[2]};
  endfunction

  function automatic logic [21:0] obs();
    return {KEY, PRESS, RELEASE, HOLD, ANY_KEY,
            KEY2, PRESS2, REL2, HOLD2, ANY2};
  endfunction

  task automatic span(int a, int b, string tag,
    logic [3:0] k, logic [3:0] p, logic [3:0] r,
    logic [3:0] h, logic [2:0] d2 = 3'b000);
    exp_t e;
    for (int c = a; c <= b; c++) begin
      e.c = c;
      e.tag = tag;
      e.v = pk(k, p, r, h, d2);
      q.push_back(e);
    end
  endtask

  task automatic chk(string tag, logic [21:0] ex);
    logic [21:0] o;
    o = obs();
    checks++;
    assert (o === ex) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %h expected %h",
             tag, cyc, o, ex);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      if (e.c < cyc) begin
        checks++;
        assert (e.c >= cyc) else begin
          errors++;
          $error("FAIL %s missed cyc %0d now %0d",
                 e.tag, e.c, cyc);
        end
      end else begin
        chk(e.tag, e.v);
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge CLK);
      cyc++;
      #1;
      drain();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    #2 RST_N = 1'b0;
    #1 chk("rst_async", 22'd0);
    span(cyc + 1, cyc + 3, "in_reset", 0, 0, 0, 0);
    run(3);
    RST_N = 1'b1;
    span(cyc + 1, cyc + 3, "idle", 0, 0, 0, 0);
    run(3);

    // ch0 press and release, latency
    t = cyc;
    in_key = 4'b1110;
    span(t + 1, t + 5, "a_wait", 0, 0, 0, 0);
    span(t + 6, t + 6, "a_press", 1, 1, 0, 0);
    span(t + 7, t + 8, "a_key", 1, 0, 0, 0);
    run(8);
    t = cyc;
    in_key = 4'hF;
    span(t + 1, t + 5, "a_rel_wait", 1, 0, 0, 0);
    span(t + 6, t + 6, "a_release", 0, 0, 1, 0);
    span(t + 7, t + 7, "a_idle", 0, 0, 0, 0);
    run(7);

    // ch1 glitch: 3 low, 1 high, 3 low
    t = cyc;
    span(t + 1, t + 13, "b_glitch", 0, 0, 0, 0);
    in_key = 4'b1101; run(3);
    in_key = 4'hF;    run(1);
    in_key = 4'b1101; run(3);
    in_key = 4'hF;    run(6);

    // ch1 bounce train then steady low
    t = cyc;
    span(t + 1, t + 10, "b_bounce", 0, 0, 0, 0);
    span(t + 11, t + 11, "b_press", 2, 2, 0, 0);
    span(t + 12, t + 13, "b_key", 2, 0, 0, 0);
    in_key = 4'b1101; run(1);
    in_key = 4'hF;    run(1);
    in_key = 4'b1101; run(2);
    in_key = 4'hF;    run(1);
    in_key = 4'b1101; run(8);
    t = cyc;
    in_key = 4'hF;
    span(t + 1, t + 5, "b_rel_wait", 2, 0, 0, 0);
    span(t + 6, t + 6, "b_release", 0, 0, 2, 0);
    span(t + 7, t + 7, "b_idle", 0, 0, 0, 0);
    run(7);

    // ch2 hold
    t = cyc;
    in_key = 4'b1011;
    span(t + 1, t + 5, "c_wait", 0, 0, 0, 0);
    span(t + 6, t + 6, "c_press", 4, 4, 0, 0);
    span(t + 7, t + 15, "c_key", 4, 0, 0, 0);
    span(t + 16, t + 26, "c_hold", 4, 0, 0, 4);
    run(26);
    t = cyc;
    in_key = 4'hF;
    span(t + 1, t + 5, "c_rel_wait", 4, 0, 0, 4);
    span(t + 6, t + 6, "c_release", 0, 0, 4, 0);
    span(t + 7, t + 7, "c_idle", 0, 0, 0, 0);
    run(7);

    // ch0+ch3 together, release ch0 then ch3
    t = cyc;
    in_key = 4'b0110;
    span(t + 1, t + 5, "d_wait", 0, 0, 0, 0);
    span(t + 6, t + 6, "d_press", 9, 9, 0, 0);
    span(t + 7, t + 8, "d_key", 9, 0, 0, 0);
    run(8);
    t = cyc;
    in_key = 4'b0111;
    span(t + 1, t + 5, "d_rel0_wait", 9, 0, 0, 0);
    span(t + 6, t + 6, "d_rel0", 8, 0, 1, 0);
    span(t + 7, t + 7, "d_key3", 8, 0, 0, 0);
    run(7);
    t = cyc;
    in_key = 4'hF;
    span(t + 1, t + 5, "d_rel3_wait", 8, 0, 0, 8);
    span(t + 6, t + 6, "d_rel3", 0, 0, 8, 0);
    span(t + 7, t + 7, "d_idle", 0, 0, 0, 0);
    run(7);

    // active-high, single-cycle debounce instance
    t = cyc;
    in2 = 1'b1;
    span(t + 1, t + 2, "e_wait", 0, 0, 0, 0, 3'b000);
    span(t + 3, t + 3, "e_press", 0, 0, 0, 0, 3'b110);
    span(t + 4, t + 4, "e_key", 0, 0, 0, 0, 3'b100);
    run(4);
    t = cyc;
    in2 = 1'b0;
    span(t + 1, t + 2, "e_rel_wait", 0, 0, 0, 0, 3'b100);
    span(t + 3, t + 3, "e_release", 0, 0, 0, 0, 3'b001);
    span(t + 4, t + 4, "e_idle", 0, 0, 0, 0, 3'b000);
    run(4);

    // reset during hold, key still down afterwards
    t = cyc;
    in_key = 4'b1101;
    span(t + 1, t + 5, "f_wait", 0, 0, 0, 0);
    span(t + 6, t + 6, "f_press", 2, 2, 0, 0);
    span(t + 7, t + 15, "f_key", 2, 0, 0, 0);
    span(t + 16, t + 18, "f_hold", 2, 0, 0, 2);
    run(18);
    RST_N = 1'b0;
    #1 chk("f_rst_async", 22'd0);
    span(cyc + 1, cyc + 2, "f_in_reset", 0, 0, 0, 0);
    run(2);
    RST_N = 1'b1;
    t = cyc;
    span(t + 1, t + 5, "f_re_wait", 0, 0, 0, 0);
    span(t + 6, t + 6, "f_re_press", 2, 2, 0, 0);
    span(t + 7, t + 7, "f_re_key", 2, 0, 0, 0);
    run(7);
    t = cyc;
    in_key = 4'hF;
    span(t + 1, t + 5, "f_rel_wait", 2, 0, 0, 0);
    span(t + 6, t + 6, "f_release", 0, 0, 2, 0);
    span(t + 7, t + 7, "f_idle", 0, 0, 0, 0);
    run(7);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_bank.md
KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

Interface
REQ-001 SHALL provide parameter N_CH, default 4: number of independent key channels (1..32).
REQ-002 SHALL provide parameter DEB_CYCLES, default 5000: consecutive stable cycles needed to accept a level change (1 .. 2^CNT_W-1).
REQ-003 SHALL provide parameter HOLD_CYCLES, default 0: debounced-press duration before HOLD asserts; 0 disables HOLD.
REQ-004 SHALL provide parameter CNT_W, default 22: width of each per-channel counter.
REQ-005 SHALL provide parameter ACTIVE_LOW_IN, default 1: 1 = raw key reads 0 when pressed, 0 = reads 1 when pressed.
REQ-006 SHALL provide port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL provide port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL provide port in_key, input, N_CH bits: raw asynchronous key levels, one bit per channel.
REQ-009 SHALL provide port KEY, output, N_CH bits: debounced level per channel, 1 = pressed regardless of ACTIVE_LOW_IN.
REQ-010 SHALL provide port PRESS, output, N_CH bits: one-cycle pulse per channel on a debounced press.
REQ-011 SHALL provide port RELEASE, output, N_CH bits: one-cycle pulse per channel on a debounced release.
REQ-012 SHALL provide port HOLD, output, N_CH bits: level per channel, high while a press has lasted at least HOLD_CYCLES.
REQ-013 SHALL provide port ANY_KEY, output, 1 bit: OR of KEY.

Function
REQ-014 SHALL pass each in_key bit through a 2-flop synchroniser, then invert it when ACTIVE_LOW_IN=1, giving sampled level s (1 = pressed).
REQ-015 SHALL keep per channel a debounced state st and a counter dc (CNT_W bits).
REQ-016 On each edge where s != st, dc SHALL increment by 1.
REQ-017 On each edge where s == st, dc SHALL clear to 0; any single agreeing sample restarts the count.
REQ-018 When s != st and dc == DEB_CYCLES-1, st SHALL toggle and dc SHALL clear on that edge.
REQ-019 Latency: after in_key changes and stays constant, KEY SHALL change on the (DEB_CYCLES+2)th rising edge, counting the first edge that samples the new level as 1.
REQ-020 A pulse on in_key shorter than DEB_CYCLES cycles, after synchronisation, SHALL NOT change KEY.
REQ-021 PRESS SHALL be high for exactly the one cycle after the edge where st goes 0->1; RELEASE likewise for st 1->0.
REQ-022 PRESS and RELEASE SHALL never be high together on one channel.
REQ-023 SHALL keep per channel a hold counter hc (CNT_W bits); hc clears whenever st == 0 and increments while st == 1.
REQ-024 hc SHALL saturate at HOLD_CYCLES; it never wraps.
REQ-025 HOLD SHALL be high while st == 1 and hc == HOLD_CYCLES.
REQ-026 HOLD SHALL drop on the same edge that KEY falls.
REQ-027 With HOLD_CYCLES = 0, HOLD SHALL be constant 0 and hc may be removed.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-029 dc SHALL never exceed DEB_CYCLES-1, so no counter wrap is possible.
REQ-030 Out-of-range parameters (DEB_CYCLES = 0 or >= 2^CNT_W, HOLD_CYCLES >= 2^CNT_W) SHALL stop elaboration with an error.

Reset
REQ-031 While RST_N = 0, SHALL asynchronously force synchroniser flops to the not-pressed raw level, st = 0, dc = 0, hc = 0.
REQ-032 While RST_N = 0, SHALL force KEY, PRESS, RELEASE, HOLD = 0 and ANY_KEY = 0.
REQ-033 After RST_N rises, a key already held down SHALL be reported as a normal press: PRESS pulse after REQ-019 latency.
REQ-034 Reset asserted mid-count or mid-hold SHALL discard all progress, with no RELEASE pulse generated.

Verification
REQ-035 N_CH=4, DEB_CYCLES=4, ACTIVE_LOW_IN=1; ch0 in_key 1->0 held -> KEY[0] rises on edge 6, PRESS[0] high 1 cycle, ANY_KEY = 1; other channels stay 0.
REQ-036 Glitch: ch1 low for 3 cycles, high 1 cycle, low 3 cycles -> KEY[1] stays 0, no PRESS; bounce train then steady low -> exactly one PRESS.
REQ-037 HOLD_CYCLES=10; hold ch2 for 20 cycles after KEY[2]=1 -> HOLD[2] rises 10 cycles after KEY[2]; on release, HOLD[2] and KEY[2] fall together with one RELEASE pulse.
REQ-038 ch0 and ch3 pressed on the same edge -> PRESS = 4'b1001 in one cycle; release ch0 only -> RELEASE = 4'b0001.
REQ-039 RST_N pulsed low while ch1 KEY = 1 and HOLD = 1 -> all outputs 0 immediately; key still down after reset -> PRESS[1] after 6 edges.
REQ-040 ACTIVE_LOW_IN=0, DEB_CYCLES=1: in_key[0] 0->1 -> KEY[0] = 1 on edge 3.
